// File: rtl/demux_1_16_16b_reg.sv
// demux_1_16_16b_reg
// Registered 1-to-16 word demultiplexer and bank. Each cycle, one input word is
// written into one of sixteen registers (A..P). The target register is chosen
// either by the select bits or by an internal auto-incrementing pointer. The
// bank also tracks which registers have been written since the last reset or
// clear.
module demux_1_16_16b_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             we,
    input  logic             auto,
    input  logic             sel3,
    input  logic             sel2,
    input  logic             sel1,
    input  logic             sel0,
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] E,
    output logic [WIDTH-1:0] F,
    output logic [WIDTH-1:0] G,
    output logic [WIDTH-1:0] H,
    output logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] L,
    output logic [WIDTH-1:0] M,
    output logic [WIDTH-1:0] N,
    output logic [WIDTH-1:0] O,
    output logic [WIDTH-1:0] P,
    output logic [3:0]       ptr,
    output logic [15:0]      mask,
    output logic             full
);

    logic [WIDTH-1:0] bank [16];
    logic [3:0]       addr;

    // Write address: the pointer in auto mode, otherwise the select bits.
    always_comb begin
        addr = {sel3, sel2, sel1, sel0};
        if (auto) begin
            addr = ptr;
        end
    end

    // Bank, pointer and mask update. Priority is rst, then clr, then a write.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < 16; i++) begin
                bank[i] <= '0;
            end
            ptr  <= 4'd0;
            mask <= 16'd0;
        end else if (we) begin
            bank[addr] <= DIN;
            mask[addr] <= 1'b1;
            if (auto) begin
                ptr <= ptr + 4'd1;
            end
        end
    end

    // The full flag is derived only from the mask register and adds no extra
    // cycle of latency.
    assign full = &mask;

    assign A = bank[0];
    assign B = bank[1];
    assign C = bank[2];
    assign D = bank[3];
    assign E = bank[4];
    assign F = bank[5];
    assign G = bank[6];
    assign H = bank[7];
    assign I = bank[8];
    assign J = bank[9];
    assign K = bank[10];
    assign L = bank[11];
    assign M = bank[12];
    assign N = bank[13];
    assign O = bank[14];
    assign P = bank[15];

endmodule
